hd44780_bus_writer: RTL

Parametrised HD44780 write-cycle engine, successor to the single-pulse write operation block. Accepts one register write (RS + 8-bit byte) via valid/ready and drives RS, RW, E and the data bus with programmable setup, pulse width, hold and execution-delay phases. Supports 8-bit and 4-bit bus modes, and applies an extended execution delay for clear/home commands. It sits between the LCD init/refresh controller and the display pins.

---
 rtl/hd44780_pkg.sv | 36 +++
 rtl/hd44780_bus_writer_timer.sv | 35 +++
 rtl/hd44780_bus_writer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hd44780_pkg.sv
// Shared types, command constants and default timings for the
// HD44780 write-cycle engine.
package hd44780_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_E_HIGH,
      ST_HOLD,
      ST_EXEC
   } state_t;

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   localparam int DEF_T_AS        = 1;
   localparam int DEF_T_PW        = 2;
   localparam int DEF_T_H         = 1;
   localparam int DEF_T_EXEC      = 4;
   localparam int DEF_T_EXEC_LONG = 100;

   function automatic bit bus_width_ok(input int w);
      return (w == 8) || (w == 4);
   endfunction

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Clear and home need the long execution delay.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
      return !rs && ((d == CMD_CLEAR) || (d == CMD_HOME) || (d == CMD_HOME_ALT));
   endfunction

endpackage

// File: rtl/hd44780_bus_writer_timer.sv
// Phase timer: loaded with N at state entry, expires on the N-th tick.
module hd44780_phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_tick,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_n,
   output logic             o_expire
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = i_n;
      end else if (i_tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign o_expire = i_tick && (cnt_q == CNT_W'(1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hd44780_bus_writer.sv
// HD44780 write-cycle engine: one RS+byte write per handshake,
// 8-bit or 4-bit bus, with setup/pulse/hold/exec phases.
module hd44780_bus_writer
   import hd44780_pkg::*;
#(
   parameter int BUS_WIDTH   = 8,
   parameter int T_AS        = DEF_T_AS,
   parameter int T_PW        = DEF_T_PW,
   parameter int T_H         = DEF_T_H,
   parameter int T_EXEC      = DEF_T_EXEC,
   parameter int T_EXEC_LONG = DEF_T_EXEC_LONG
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_ena,
   input  logic                 i_valid,
   input  logic                 i_rs,
   input  logic [7:0]           i_data,
   output logic                 o_ready,
   output logic                 o_rs,
   output logic                 o_rw,
   output logic                 o_e,
   output logic [BUS_WIDTH-1:0] o_db,
   output logic                 o_done
);

   localparam int T_MAX = max_i(max_i(max_i(T_AS, T_PW), max_i(T_H, T_EXEC)), T_EXEC_LONG);
   localparam int CNT_W = $clog2(T_MAX) + 1;

   if (!bus_width_ok(BUS_WIDTH)) begin : g_bad_width
      $error("hd44780_bus_writer: BUS_WIDTH must be 8 or 4");
   end

   state_t               state_q, state_d;
   logic                 rs_q, rs_d;
   logic [BUS_WIDTH-1:0] db_q, db_d;
   logic [7:0]           data_q, data_d;
   logic                 long_q, long_d;
   logic                 nib_q, nib_d;
   logic                 done_q, done_d;
   logic                 ld;
   logic [CNT_W-1:0]     ld_n;
   logic                 expire;

   hd44780_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_tick   (i_ena),
      .i_load   (ld),
      .i_n      (ld_n),
      .o_expire (expire)
   );

   always_comb begin
      state_d = state_q;
      rs_d    = rs_q;
      db_d    = db_q;
      data_d  = data_q;
      long_d  = long_q;
      nib_d   = nib_q;
      done_d  = 1'b0;
      ld      = 1'b0;
      ld_n    = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               rs_d    = i_rs;
               data_d  = i_data;
               long_d  = is_long_cmd(i_rs, i_data);
               nib_d   = 1'b0;
               db_d    = i_data[7 -: BUS_WIDTH];
               state_d = ST_SETUP;
               ld      = 1'b1;
               ld_n    = CNT_W'(T_AS);
            end
         end
         ST_SETUP: begin
            if (expire) begin
               state_d = ST_E_HIGH;
               ld      = 1'b1;
               ld_n    = CNT_W'(T_PW);
            end
         end
         ST_E_HIGH: begin
            if (expire) begin
               state_d = ST_HOLD;
               ld      = 1'b1;
               ld_n    = CNT_W'(T_H);
            end
         end
         ST_HOLD: begin
            if (expire) begin
               ld = 1'b1;
               // Low nibble goes out on a second strobe in 4-bit mode.
               if ((BUS_WIDTH == 4) && !nib_q) begin
                  nib_d   = 1'b1;
                  db_d    = data_q[BUS_WIDTH-1:0];
                  state_d = ST_SETUP;
                  ld_n    = CNT_W'(T_AS);
               end else begin
                  state_d = ST_EXEC;
                  ld_n    = long_q ? CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC);
               end
            end
         end
         ST_EXEC: begin
            if (expire) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         rs_q    <= 1'b0;
         db_q    <= '0;
         data_q  <= '0;
         long_q  <= 1'b0;
         nib_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         db_q    <= db_d;
         data_q  <= data_d;
         long_q  <= long_d;
         nib_q   <= nib_d;
         done_q  <= done_d;
      end
   end

   assign o_ready = (state_q == ST_IDLE);
   assign o_e     = (state_q == ST_E_HIGH);
   assign o_rs    = rs_q;
   assign o_rw    = 1'b0;
   assign o_db    = db_q;
   assign o_done  = done_q;

endmodule
